locked_reg_bank: RTL and testbench

LOCKED_REG_BANK -- requirements
Module: locked_reg_bank

---
 rtl/locked_reg_bank.sv | 132 +++++++++++++
 tb/tb_locked_reg_bank.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/locked_reg_bank.sv
// Register bank whose writes open only after a two-key unlock sequence.
// Repeated wrong keys lead to a lockout that only reset clears.
module locked_reg_bank #(
  parameter int              WIDTH     = 8,
  parameter int              NUM_REGS  = 4,
  parameter logic [WIDTH-1:0] KEY0     = 8'hA5,
  parameter logic [WIDTH-1:0] KEY1     = 8'h5A,
  parameter int              WINDOW    = 16,
  parameter int              MAX_FAILS = 3,
  localparam int             AW        = (NUM_REGS <= 2) ? 1 : $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [WIDTH-1:0] key_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             unlocked,
  output logic             lockout,
  output logic             wr_err,
  output logic             key_err
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);
  localparam logic [WW-1:0] WIN_LOAD = WW'(WINDOW - 1);
  // One extra bit so the range check is meaningful even when NUM_REGS is a power of two.
  localparam logic [AW:0]   NR_W     = (AW + 1)'(NUM_REGS);

  localparam logic [1:0] S_LOCKED    = 2'd0;
  localparam logic [1:0] S_KEY1_WAIT = 2'd1;
  localparam logic [1:0] S_UNLOCKED  = 2'd2;
  localparam logic [1:0] S_LOCKOUT   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [FW-1:0]    fail_cnt_q, fail_cnt_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d;
  logic             key_err_q, key_err_d;
  logic             wr_err_q, wr_err_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic             bad_key;
  logic             wr_ok;
  logic             rd_ok;

  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    win_cnt_d  = win_cnt_q;
    key_err_d  = 1'b0;
    bad_key    = 1'b0;
    case (state_q)
      S_LOCKED: begin
        if (key_valid) begin
          if (key_data == KEY0) state_d = S_KEY1_WAIT;
          else                  bad_key = 1'b1;
        end
      end
      S_KEY1_WAIT: begin
        if (key_valid) begin
          if (key_data == KEY1) begin
            state_d    = S_UNLOCKED;
            win_cnt_d  = WIN_LOAD;
            fail_cnt_d = '0;
          end else begin
            state_d = S_LOCKED;
            bad_key = 1'b1;
          end
        end
      end
      S_UNLOCKED: begin
        if (key_valid || win_cnt_q == '0) begin
          state_d   = S_LOCKED;
          win_cnt_d = '0;
        end else begin
          win_cnt_d = win_cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
    // A wrong key that brings the count to the limit overrides the normal next state.
    if (bad_key) begin
      key_err_d = 1'b1;
      if (fail_cnt_q != FAIL_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
      if (fail_cnt_d == FAIL_MAX) state_d = S_LOCKOUT;
    end
  end

  always_comb begin
    wr_ok     = wr_en && (state_q == S_UNLOCKED) && ({1'b0, wr_addr} < NR_W);
    wr_err_d  = wr_en && !wr_ok;
    rd_ok     = ({1'b0, rd_addr} < NR_W);
    rd_data_d = rd_ok ? regs_q[rd_addr] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOCKED;
      fail_cnt_q <= '0;
      win_cnt_q  <= '0;
      key_err_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      win_cnt_q  <= win_cnt_d;
      key_err_q  <= key_err_d;
      wr_err_q   <= wr_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign unlocked = (state_q == S_UNLOCKED);
  assign lockout  = (state_q == S_LOCKOUT);
  assign wr_err   = wr_err_q;
  assign key_err  = key_err_q;

endmodule

// File: tb/tb_locked_reg_bank.sv
// Scoreboard bench for locked_reg_bank: a behavioural model predicts every
// cycle's outputs, a monitor compares them on the falling edge.
module tb_locked_reg_bank;
  localparam int NR = 3;
  localparam int WIN = 16;
  localparam int MAXF = 3;
  localparam logic [7:0] K0 = 8'hA5;
  localparam logic [7:0] K1 = 8'h5A;

  logic       clk, reset, key_valid, wr_en;
  logic [7:0] key_data, wr_data, rd_data;
  logic [1:0] wr_addr, rd_addr;
  logic       unlocked, lockout, wr_err, key_err;

  locked_reg_bank #(.WIDTH(8), .NUM_REGS(NR), .KEY0(K0), .KEY1(K1),
                    .WINDOW(WIN), .MAX_FAILS(MAXF)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_data(key_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .unlocked(unlocked), .lockout(lockout),
    .wr_err(wr_err), .key_err(key_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rd;
    logic       unl;
    logic       lko;
    logic       werr;
    logic       kerr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  event mon_ev;
  int   n_checks = 0;
  int   n_pass = 0;

  // Model state: plain counters of remaining window cycles and failures.
  logic [7:0] m_regs [NR];
  bit         m_unl, m_lko, m_have_k0;
  int         m_left, m_fails;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, want);
  endtask

  always @(negedge clk or mon_ev) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rd_data",  rd_data,         mon_e.rd);
      chk("unlocked", {7'd0, unlocked}, {7'd0, mon_e.unl});
      chk("lockout",  {7'd0, lockout},  {7'd0, mon_e.lko});
      chk("wr_err",   {7'd0, wr_err},   {7'd0, mon_e.werr});
      chk("key_err",  {7'd0, key_err},  {7'd0, mon_e.kerr});
      $display("txn: rd=%02h unl=%0d lko=%0d werr=%0d kerr=%0d",
               rd_data, unlocked, lockout, wr_err, key_err);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_unl = 0; m_lko = 0; m_have_k0 = 0; m_left = 0; m_fails = 0;
  endtask

  task automatic wrong_key(output bit kerr);
    kerr = 1;
    m_have_k0 = 0;
    if (m_fails < MAXF) m_fails++;
    if (m_fails == MAXF) m_lko = 1;
  endtask

  task automatic model_step(input logic kv, input logic [7:0] kd, input logic we,
                            input logic [1:0] wa, input logic [7:0] wd,
                            input logic [1:0] ra, output exp_t e);
    bit accept, kerr;
    kerr   = 0;
    accept = we && m_unl && (int'(wa) < NR);
    e.rd   = (int'(ra) < NR) ? m_regs[ra] : 8'h00;
    if (m_lko) begin
    end else if (m_unl) begin
      m_left--;
      if (kv || m_left == 0) m_unl = 0;
    end else if (m_have_k0) begin
      if (kv) begin
        if (kd == K1) begin
          m_unl = 1; m_left = WIN; m_fails = 0; m_have_k0 = 0;
        end else wrong_key(kerr);
      end
    end else if (kv) begin
      if (kd == K0) m_have_k0 = 1;
      else wrong_key(kerr);
    end
    if (accept) m_regs[wa] = wd;
    e.unl = m_unl; e.lko = m_lko; e.werr = we && !accept; e.kerr = kerr;
  endtask

  task automatic cycle(input logic kv, input logic [7:0] kd, input logic we,
                       input logic [1:0] wa, input logic [7:0] wd, input logic [1:0] ra);
    exp_t e;
    key_valid = kv; key_data = kd; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    model_step(kv, kd, we, wa, wd, ra, e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] ra);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 2'd0, 8'h00, ra);
  endtask

  task automatic unlock();
    cycle(1, K0, 0, 2'd0, 8'h00, 2'd0);
    cycle(1, K1, 0, 2'd0, 8'h00, 2'd0);
  endtask

  // Reset rises between clock edges with a write pending; outputs are checked before the next edge.
  task automatic async_reset();
    exp_t e;
    @(negedge clk);
    #1;
    wr_en = 1; wr_addr = 2'd1; wr_data = 8'hEE; key_valid = 0;
    reset = 1;
    #1;
    model_reset();
    e.rd = 8'h00; e.unl = 0; e.lko = 0; e.werr = 0; e.kerr = 0;
    exp_q.push_back(e);
    -> mon_ev;
    @(posedge clk);
    #1;
    reset = 0; wr_en = 0;
  endtask

  initial begin
    exp_t e;
    reset = 1; key_valid = 0; key_data = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    model_reset();
    @(posedge clk);
    #1;
    e.rd = 8'h00; e.unl = 0; e.lko = 0; e.werr = 0; e.kerr = 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    reset = 0;

    // Write while locked
    cycle(0, 8'h00, 1, 2'd1, 8'hFF, 2'd1);
    idle(2, 2'd1);

    // Unlock, write, window expiry, late write
    unlock();
    cycle(0, 8'h00, 1, 2'd2, 8'h3C, 2'd2);
    idle(15, 2'd2);
    cycle(0, 8'h00, 1, 2'd2, 8'h77, 2'd2);
    idle(2, 2'd2);

    // Failure count cleared by a successful unlock
    cycle(1, 8'h00, 0, 2'd0, 8'h00, 2'd0);
    unlock();
    cycle(1, 8'h11, 0, 2'd0, 8'h00, 2'd0);
    cycle(1, 8'h00, 0, 2'd0, 8'h00, 2'd0);
    cycle(1, 8'h00, 0, 2'd0, 8'h00, 2'd0);
    idle(2, 2'd0);

    // Write in the last window cycle, write with relock, out-of-range write
    unlock();
    idle(15, 2'd0);
    cycle(0, 8'h00, 1, 2'd0, 8'h5E, 2'd0);
    idle(2, 2'd0);
    unlock();
    cycle(1, 8'h22, 1, 2'd1, 8'h99, 2'd1);
    idle(2, 2'd1);
    unlock();
    cycle(0, 8'h00, 1, 2'd3, 8'h44, 2'd3);
    cycle(1, 8'h00, 0, 2'd0, 8'h00, 2'd3);
    idle(1, 2'd0);

    // Lockout after three wrong keys, keys ignored, reset clears it
    for (int i = 0; i < 3; i++) cycle(1, 8'h00, 0, 2'd0, 8'h00, 2'd2);
    unlock();
    cycle(1, 8'h00, 0, 2'd0, 8'h00, 2'd2);
    cycle(0, 8'h00, 1, 2'd0, 8'h12, 2'd0);
    async_reset();
    idle(2, 2'd0);

    // Reset mid-window with a write pending
    unlock();
    cycle(0, 8'h00, 1, 2'd0, 8'hA1, 2'd0);
    cycle(0, 8'h00, 1, 2'd1, 8'hB2, 2'd0);
    cycle(0, 8'h00, 1, 2'd2, 8'hC3, 2'd1);
    async_reset();
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 2'd0, 8'h00, 2'(i));
    idle(1, 2'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] kd;
      if (i % 90 == 89) begin
        async_reset();
      end else begin
        r  = $urandom_range(0, 9);
        kd = (r < 3) ? K0 : (r < 6) ? K1 : 8'($urandom);
        cycle(r < 7 && ($urandom_range(0, 2) != 0), kd, 1'($urandom),
              2'($urandom), 8'($urandom), 2'($urandom));
      end
    end

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
